// File: rtl/hil_axil_slave_regs.sv
// AXI4-Lite slave exposing four 32-bit registers to a HIL controller.
// Independent read and write FSMs; byte-lane writes; offsets 0x10-0x1C answer SLVERR.
module hil_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     hil_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     hil_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     hil_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     hil_reg3,
    output logic [3:0]                        hil_wr_strobe
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR_HELD,
        W_DATA_HELD,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    wstate_t          r_wstate;
    rstate_t          r_rstate;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic [3:0]       r_wr_strobe;
    logic [AW-1:0]    r_aw_addr;
    logic [DW-1:0]    r_w_data;
    logic [SW-1:0]    r_w_strb;
    logic             r_arready;
    logic             r_rvalid;
    logic [1:0]       r_rresp;
    logic [DW-1:0]    r_rdata;
    logic [DW-1:0]    r_regs [4];

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_commit;
    logic [AW-1:0]    w_cm_addr;
    logic [DW-1:0]    w_cm_data;
    logic [SW-1:0]    w_cm_strb;
    logic             w_cm_mapped;
    logic [1:0]       w_cm_idx;
    logic             w_rd_mapped;
    logic [1:0]       w_rd_idx;
    logic             w_unused_ok;

    // Handshakes use the registered readies, so no valid input reaches a ready output.
    assign w_aw_hs = s00_axi_awvalid & r_awready;
    assign w_w_hs  = s00_axi_wvalid  & r_wready;
    assign w_ar_hs = s00_axi_arvalid & r_arready;

    assign w_rd_mapped = (s00_axi_araddr[AW-1:4] == '0);
    assign w_rd_idx    = s00_axi_araddr[3:2];
    assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Whichever channel completes last supplies its payload directly from the bus.
    always_comb begin
        w_cm_addr   = (r_wstate == W_ADDR_HELD) ? r_aw_addr : s00_axi_awaddr;
        w_cm_data   = (r_wstate == W_DATA_HELD) ? r_w_data  : s00_axi_wdata;
        w_cm_strb   = (r_wstate == W_DATA_HELD) ? r_w_strb  : s00_axi_wstrb;
        w_cm_mapped = (w_cm_addr[AW-1:4] == '0);
        w_cm_idx    = w_cm_addr[3:2];
        w_commit    = ((r_wstate == W_IDLE)      && w_aw_hs && w_w_hs)
                   || ((r_wstate == W_ADDR_HELD) && w_w_hs)
                   || ((r_wstate == W_DATA_HELD) && w_aw_hs);
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_wr_strobe <= '0;
            r_aw_addr   <= '0;
            r_w_data    <= '0;
            r_w_strb    <= '0;
        end else begin
            r_wr_strobe <= '0;
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_ADDR_HELD;
                        r_aw_addr <= s00_axi_awaddr;
                        r_awready <= 1'b0;
                    end else if (w_w_hs) begin
                        r_wstate <= W_DATA_HELD;
                        r_w_data <= s00_axi_wdata;
                        r_w_strb <= s00_axi_wstrb;
                        r_wready <= 1'b0;
                    end
                end
                W_ADDR_HELD: begin
                    if (w_commit) begin
                        r_wstate <= W_RESP;
                        r_wready <= 1'b0;
                    end
                end
                W_DATA_HELD: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_cm_mapped ? RESP_OKAY : RESP_SLVERR;
                if (w_cm_mapped) begin
                    r_wr_strobe[w_cm_idx] <= 1'b1;
                end
            end
        end
    end

    // NOTE: the register array is reset explicitly because the HIL controller sees it directly.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_cm_mapped) begin
            for (int b = 0; b < SW; b++) begin
                if (w_cm_strb[b]) begin
                    r_regs[w_cm_idx][8*b +: 8] <= w_cm_data[8*b +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking updates mean a read sampling r_regs on a commit edge sees the old value.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_mapped ? r_regs[w_rd_idx] : '0;
                        r_rresp   <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;
    assign hil_reg0        = r_regs[0];
    assign hil_reg1        = r_regs[1];
    assign hil_reg2        = r_regs[2];
    assign hil_reg3        = r_regs[3];
    assign hil_wr_strobe   = r_wr_strobe;

endmodule
